// File: rtl/aww_types_pkg.sv
// Shared types and helpers for the branch predictor: entry layout, counter
// encodings and saturating counter arithmetic.
package aww_types_pkg;

  localparam int unsigned BP_ENTRIES = 16;
  localparam int unsigned BP_CTR_W   = 2;
  localparam int unsigned BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int unsigned BP_TAG_W   = 30 - BP_IDX_W;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    logic [BP_CTR_W-1:0] ctr;
  } bp_entry_t;

  localparam logic [BP_CTR_W-1:0] BP_CTR_WEAK_T  = BP_CTR_W'(1) << (BP_CTR_W - 1);
  localparam logic [BP_CTR_W-1:0] BP_CTR_WEAK_NT = BP_CTR_WEAK_T - BP_CTR_W'(1);

  // Width-generic so callers with a non-default counter width can share them.
  function automatic logic [31:0] bp_sat_inc(input logic [31:0] ctr, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (ctr >= max_v) ? ctr : ctr + 32'd1;
  endfunction

  function automatic logic [31:0] bp_sat_dec(input logic [31:0] ctr, input int unsigned width);
    logic [31:0] unused_w;
    unused_w = 32'(width);
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped predictor storage: two asynchronous read ports (fetch lookup
// and update-side hit check) and one synchronous write port.
module bp_table #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  localparam int unsigned IDX_W  = $clog2(ENTRIES),
  localparam int unsigned TAG_W  = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush_all,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  logic [CTR_W-1:0] wr_ctr,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_valid,
  output logic [TAG_W-1:0] lk_tag,
  output logic [31:0]      lk_target,
  output logic             lk_ctr_msb,
  input  logic [IDX_W-1:0] up_idx,
  output logic             up_valid,
  output logic [TAG_W-1:0] up_tag,
  output logic [31:0]      up_target,
  output logic [CTR_W-1:0] up_ctr
);

  localparam logic [CTR_W-1:0] WeakNt = (CTR_W'(1) << (CTR_W - 1)) - CTR_W'(1);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  // Flush only drops valid bits and wins over a concurrent write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WeakNt;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

  always_comb begin
    lk_valid   = valid_q[lk_idx];
    lk_tag     = tag_q[lk_idx];
    lk_target  = target_q[lk_idx];
    lk_ctr_msb = ctr_q[lk_idx][CTR_W-1];
    up_valid   = valid_q[up_idx];
    up_tag     = tag_q[up_idx];
    up_target  = target_q[up_idx];
    up_ctr     = ctr_q[up_idx];
  end

endmodule

// File: rtl/branch_predictor_table.sv
// Entry storage for the predictor is implemented by module bp_table in
// bp_table.sv; no additional logic is defined here.

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + saturating-counter predictor with registered mispredict.
// Optional BP_STATS_EN adds update / mispredict event counters.
module branch_predictor
  import aww_types_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES,
  parameter int unsigned CTR_W   = BP_CTR_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_npc,
  input  logic        upd_valid,
  input  logic        pipe_wen,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_npc,
  input  logic        flush_all,
  output logic        mispredict,
  output logic [31:0] correct_npc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] WeakT = CTR_W'(1) << (CTR_W - 1);

  logic             lk_valid, lk_ctr_msb;
  logic [TAG_W-1:0] lk_tag;
  logic [31:0]      lk_target;
  logic             up_valid;
  logic [TAG_W-1:0] up_tag;
  logic [31:0]      up_target;
  logic [CTR_W-1:0] up_ctr;

  logic             upd_en, up_hit, wr_en;
  logic [31:0]      wr_target, resolved_npc;
  logic [CTR_W-1:0] wr_ctr;
  logic             miss_d;

  bp_table #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W)
  ) u_table (
    .CLK        (CLK),
    .RST        (RST),
    .flush_all  (flush_all),
    .wr_en      (wr_en),
    .wr_idx     (upd_pc[IDX_W+1:2]),
    .wr_tag     (upd_pc[31:IDX_W+2]),
    .wr_target  (wr_target),
    .wr_ctr     (wr_ctr),
    .lk_idx     (if_pc[IDX_W+1:2]),
    .lk_valid   (lk_valid),
    .lk_tag     (lk_tag),
    .lk_target  (lk_target),
    .lk_ctr_msb (lk_ctr_msb),
    .up_idx     (upd_pc[IDX_W+1:2]),
    .up_valid   (up_valid),
    .up_tag     (up_tag),
    .up_target  (up_target),
    .up_ctr     (up_ctr)
  );

  always_comb begin
    pred_hit   = lk_valid && (lk_tag == if_pc[31:IDX_W+2]);
    pred_taken = pred_hit && lk_ctr_msb;
    pred_npc   = pred_taken ? lk_target : if_pc + 32'd4;
  end

  // A miss that resolves not-taken leaves the table untouched.
  always_comb begin
    upd_en       = upd_valid && pipe_wen;
    up_hit       = up_valid && (up_tag == upd_pc[31:IDX_W+2]);
    wr_en        = upd_en && (up_hit || upd_taken);
    resolved_npc = upd_taken ? upd_target : upd_pc + 32'd4;
    miss_d       = upd_valid && (resolved_npc != upd_pred_npc);
    wr_target    = upd_taken ? upd_target : up_target;
    if (!up_hit) begin
      wr_ctr = WeakT;
    end else if (upd_taken) begin
      wr_ctr = CTR_W'(bp_sat_inc(32'(up_ctr), CTR_W));
    end else begin
      wr_ctr = CTR_W'(bp_sat_dec(32'(up_ctr), CTR_W));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mispredict  <= 1'b0;
      correct_npc <= '0;
    end else if (pipe_wen) begin
      mispredict  <= miss_d;
      correct_npc <= resolved_npc;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_en) stat_updates <= stat_updates + 32'd1;
      if (pipe_wen && miss_d) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  // The carried prediction direction is implied by upd_pred_npc.
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised direct-mapped branch predictor with a branch target buffer (BTB) and saturating-counter direction table. It sits beside the PC unit in the IF stage and supplies a predicted next PC every cycle. It is trained by branch/jump resolution from the EX stage. A registered mispredict indication lets the datapath flush IF/ID and ID/EX when a branch resolves differently from its prediction.

## Interface
- ENTRIES, 16, number of table entries; power of two, ≥ 2; IDX_W = $clog2(ENTRIES)
- CTR_W, 2, direction counter width; ≥ 1
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- if_pc  in  32  PC currently being fetched
- pred_hit  out  1  valid entry with matching tag for if_pc
- pred_taken  out  1  pred_hit & counter MSB set
- pred_npc  out  32  pred_taken ? stored target : if_pc + 4
- upd_valid  in  1  EX resolved a branch/jump this cycle; sampled only when pipe_wen=1
- pipe_wen  in  1  pipeline advance enable (ihit | dhit)
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  32  actual target
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction
- upd_pred_npc  in  32  predicted next PC carried down the pipe
- flush_all  in  1  invalidate the entire table
- mispredict  out  1  registered; resolved next PC ≠ upd_pred_npc
- correct_npc  out  32  registered; upd_taken ? upd_target : upd_pc + 4

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target[31:0], ctr[CTR_W-1:0].
- Lookup is purely combinational from if_pc and the current table contents.
- Update applies when upd_valid & pipe_wen:
  - Hit, taken: ctr = sat_inc(ctr); target = upd_target.
  - Hit, not taken: ctr = sat_dec(ctr); target unchanged.
  - Miss, taken: allocate and overwrite the entry; valid=1, tag, target, ctr = weak-taken (MSB=1, rest 0).
  - Miss, not taken: no change.
- Counters saturate at all-ones and at zero; they never wrap.
- mispredict/correct_npc are registered on every cycle in which pipe_wen=1:
  - mispredict = upd_valid & (resolved_npc ≠ upd_pred_npc).
  - resolved_npc is upd_taken ? upd_target : upd_pc + 4.
  - When pipe_wen=0, both outputs hold their values.
- flush_all clears every valid bit on the next edge and has priority over a simultaneous update.
- All PC arithmetic is 32-bit modulo; 0xFFFFFFFC + 4 = 0.

## Timing
- Lookup latency is 0 cycles. An update is visible to lookup on the cycle after its edge.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. There is no bypass.
- mispredict is valid 1 cycle after the resolving upd_valid and is held while stalled.
- Reset (asynchronous, mid-operation allowed) takes effect immediately:
  - All valid=0, ctr = weak-not-taken (MSB=0, rest 1), target=0.
  - mispredict=0, correct_npc=0.
  - Therefore pred_hit=0, pred_taken=0, pred_npc=if_pc+4.
  - Statistics counters = 0.

## Configuration
- BP_STATS_EN:
  - When defined, adds outputs stat_updates[31:0] and stat_mispredicts[31:0].
  - Each increments on the cycle its registered event is latched: any applied update, and each mispredict=1 latch.
  - Both are 32-bit, wrap at 2^32, cleared by RST and not by flush_all.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

## Structure
- aww_types_pkg gains:
  - bp_entry_t (packed valid/tag/target/ctr, parametrised through localparams).
  - Constants BP_CTR_WEAK_T and BP_CTR_WEAK_NT.
  - Functions bp_sat_inc and bp_sat_dec.
- One sub-module, bp_table:
  - Entry storage with an asynchronous read port and a synchronous write port.
  - flush-all and reset clear.
  - The top level holds the index/tag split, the update decision and the mispredict register.

## Test plan
- Reset, then if_pc=0x40 → pred_hit=0, pred_taken=0, pred_npc=0x44; mispredict=0.
- Update upd_pc=0x40, taken, target=0x100, pipe_wen=1; next cycle if_pc=0x40 → pred_hit=1, pred_taken=1, pred_npc=0x100.
- Aliasing: with 0x40 trained, if_pc=0x440 (same index 0, tag 0x11 vs 0x1) → pred_hit=0, pred_npc=0x444.
- Saturation (CTR_W=2): after allocate, apply 3 taken updates (ctr=11), then 1 not-taken → still taken; 2nd not-taken → ctr=01, pred_hit=1, pred_npc=pc+4.
- Mispredict and stall: upd_pred_npc=0x44, actual taken to 0x100 → next cycle mispredict=1, correct_npc=0x100. Hold pipe_wen=0 for 3 cycles → outputs stable. With BP_STATS_EN, stat_mispredicts=1.
- flush_all and update asserted the same cycle → all lookups miss afterwards. Assert RST mid-run → outputs return to reset values without a clock edge.
